// File: rtl/fnd_pkg.sv
// Shared types and 7-segment glyph table for the FND stopwatch display path.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package fnd_pkg;

  typedef logic [3:0] bcd_t;

  // Segment order {g,f,e,d,c,b,a}, 1 = segment lit (polarity applied at the pins).
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-decimal codes never occur in a BCD counter; show them as blank.
  function automatic logic [6:0] bcd_to_seg(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// Clock-enable generator: one-cycle o_tick every floor(CLK_HZ/OUT_HZ) sysclk cycles.
// Latency: first tick on the DIV-th cycle after reset is released.
// Backpressure: none, free-running.
// Ports: sysclk, i_reset (sync, active-high), o_tick (1-cycle enable).
module fnd_tick_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int OUT_HZ = 1000
) (
  input  logic sysclk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int DIV = (CLK_HZ / OUT_HZ < 1) ? 1 : CLK_HZ / OUT_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge sysclk) begin
    if (i_reset || cnt_q == LAST) cnt_q <= '0;
    else                          cnt_q <= cnt_q + 1'b1;
  end

  assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/fnd_stopwatch_scan.sv
// N-digit BCD stopwatch (run/hold, lap freeze, clear, leading-zero blanking) scanned onto one 7-seg+DP bus.
// Latency: glyph/select registered, valid one cycle after the scan index moves; counter updates on the tick cycle.
// Backpressure: none; pulse inputs are consumed in the cycle they are seen.
// Ports: sysclk, i_reset, i_run, i_lap, i_clear in; o_fndOut {dp,g..a}, o_fndSelect, o_running, o_lap out.
module fnd_stopwatch_scan
  import fnd_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int TICK_HZ  = 10,
  parameter int N_DIGITS = 4,
  parameter bit ACT_LOW  = 1'b1
) (
  input  logic                sysclk,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic                i_lap,
  input  logic                i_clear,
  output logic [7:0]          o_fndOut,
  output logic [N_DIGITS-1:0] o_fndSelect,
  output logic                o_running,
  output logic                o_lap
);

  localparam int IW = $clog2(N_DIGITS);
  localparam logic [N_DIGITS-1:0] SEL0   = {{(N_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [7:0]          GLYPH0 = {1'b0, SEG_0};

  logic count_tick, scan_tick;

  fnd_tick_gen #(.CLK_HZ(CLK_HZ), .OUT_HZ(TICK_HZ)) u_count_tick (
    .sysclk (sysclk), .i_reset(i_reset), .o_tick(count_tick));

  fnd_tick_gen #(.CLK_HZ(CLK_HZ), .OUT_HZ(SCAN_HZ)) u_scan_tick (
    .sysclk (sysclk), .i_reset(i_reset), .o_tick(scan_tick));

  bcd_t [N_DIGITS-1:0] cnt_q, cnt_d, snap_q, snap_d, inc, disp;
  logic                lap_q, lap_d, carry;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_DIGITS-1:0] lead_zero;
  logic [6:0]          seg;
  logic                dp, blank;
  logic [7:0]          glyph;
  logic [N_DIGITS-1:0] sel;

  // Ripple increment: digit 2 (tens of seconds) wraps at 5, all others at 9.
  always_comb begin
    inc   = cnt_q;
    carry = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (carry) begin
        if (cnt_q[k] == ((k == 2) ? 4'd5 : 4'd9)) begin
          inc[k] = 4'd0;
        end else begin
          inc[k] = cnt_q[k] + 4'd1;
          carry  = 1'b0;
        end
      end
    end
  end

  // Clear overrides lap; a lap entry snapshots the post-tick value.
  always_comb begin
    cnt_d  = cnt_q;
    snap_d = snap_q;
    lap_d  = lap_q;
    if (count_tick && i_run) cnt_d = inc;
    if (i_clear) begin
      cnt_d = '0;
      lap_d = 1'b0;
    end else if (i_lap) begin
      lap_d = ~lap_q;
      if (!lap_q) snap_d = cnt_d;
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (scan_tick) idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  // lead_zero[k]: digit k and every digit above it are zero.
  always_comb begin
    disp                  = lap_q ? snap_q : cnt_q;
    lead_zero[N_DIGITS-1] = (disp[N_DIGITS-1] == 4'd0);
    for (int k = N_DIGITS - 2; k >= 0; k--) begin
      lead_zero[k] = lead_zero[k+1] && (disp[k] == 4'd0);
    end
  end

  always_comb begin
    blank = (int'(idx_q) >= 2) && lead_zero[idx_q];
    seg   = blank ? SEG_BLANK : bcd_to_seg(disp[idx_q]);
    dp    = (int'(idx_q) == 1);
    glyph = {dp, seg};
    sel   = SEL0 << idx_q;
  end

  always_ff @(posedge sysclk) begin
    if (i_reset) begin
      cnt_q       <= '0;
      snap_q      <= '0;
      lap_q       <= 1'b0;
      idx_q       <= '0;
      o_fndOut    <= ACT_LOW ? ~GLYPH0 : GLYPH0;
      o_fndSelect <= ACT_LOW ? ~SEL0 : SEL0;
      o_running   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      lap_q       <= lap_d;
      idx_q       <= idx_d;
      o_fndOut    <= ACT_LOW ? ~glyph : glyph;
      o_fndSelect <= ACT_LOW ? ~sel : sel;
      o_running   <= i_run;
    end
  end

  assign o_lap = lap_q;

endmodule

// File: tb/tb_fnd_stopwatch_scan.sv
// Bench for fnd_stopwatch_scan: two instances (count divider 100 and 4) share the inputs.
// Each cycle both are compared with a model that keeps the elapsed time as a plain tenths count.
// Directed scenarios plus a randomized phase; expected glyphs come from digit arithmetic.
module tb_fnd_stopwatch_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run, lap, clr;
  logic [7:0] out_s, out_f;
  logic [3:0] sel_s, sel_f;
  logic       running_s, running_f, lap_s, lap_f;

  fnd_stopwatch_scan #(.CLK_HZ(1000), .SCAN_HZ(100), .TICK_HZ(10), .N_DIGITS(4), .ACT_LOW(1'b1)) u_dut (
    .sysclk(clk), .i_reset(rst), .i_run(run), .i_lap(lap), .i_clear(clr),
    .o_fndOut(out_s), .o_fndSelect(sel_s), .o_running(running_s), .o_lap(lap_s));

  // Fast-counting copy so the minute carry and full wrap fit in a short run.
  fnd_stopwatch_scan #(.CLK_HZ(1000), .SCAN_HZ(100), .TICK_HZ(250), .N_DIGITS(4), .ACT_LOW(1'b1)) u_fast (
    .sysclk(clk), .i_reset(rst), .i_run(run), .i_lap(lap), .i_clear(clr),
    .o_fndOut(out_f), .o_fndSelect(sel_f), .o_running(running_f), .o_lap(lap_f));

  int n_vec = 0;
  int n_err = 0;

  // Model state: elapsed tenths per instance, lap/snapshot, shared scan position and cycle count.
  int         m_cnt[2], m_snap[2];
  bit         m_lap[2];
  int         m_idx, m_cyc;
  bit         m_valid = 1'b0;
  logic [11:0] e_frame[2];
  bit         e_run;
  logic [7:0] seen[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int tdiv(input int i);
    return (i == 0) ? 100 : 4;
  endfunction

  function automatic int wgt(input int k);
    case (k)
      0: return 1;
      1: return 10;
      2: return 100;
      default: return 600;
    endcase
  endfunction

  function automatic int mdl(input int k);
    return (k == 2) ? 6 : 10;
  endfunction

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; default: return 7'h6F;
    endcase
  endfunction

  // Active-low {glyph, select} for digit idx of a value in tenths.
  function automatic logic [11:0] frame(input int idx, input int val);
    logic [6:0] sg;
    logic [3:0] one;
    int dv;
    bit blank;
    one   = 4'b0001;
    dv    = (val / wgt(idx)) % mdl(idx);
    blank = (idx >= 2) && (val < wgt(idx));
    sg    = blank ? 7'h00 : seg7(dv);
    return {~{(idx == 1), sg}, ~(one << idx)};
  endfunction

  function automatic void model_update();
    bit stick, tt;
    int nv;
    for (int i = 0; i < 2; i++) e_frame[i] = frame(m_idx, m_lap[i] ? m_snap[i] : m_cnt[i]);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_snap[i] = 0; m_lap[i] = 1'b0;
        e_frame[i] = frame(0, 0);
      end
      m_idx = 0; m_cyc = 0; e_run = 1'b0; m_valid = 1'b1;
    end else begin
      e_run = run;
      stick = (m_cyc % 10) == 9;
      for (int i = 0; i < 2; i++) begin
        tt = (m_cyc % tdiv(i)) == tdiv(i) - 1;
        nv = (tt && run) ? (m_cnt[i] + 1) % 6000 : m_cnt[i];
        if (clr) begin
          m_cnt[i] = 0; m_lap[i] = 1'b0;
        end else begin
          m_cnt[i] = nv;
          if (lap) begin
            if (!m_lap[i]) begin m_snap[i] = nv; m_lap[i] = 1'b1; end
            else m_lap[i] = 1'b0;
          end
        end
      end
      if (stick) m_idx = (m_idx + 1) % 4;
      m_cyc++;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    if (m_valid) begin
      check("slow_outs", {18'b0, out_s, sel_s, running_s, lap_s}, {18'b0, e_frame[0], e_run, m_lap[0]});
      check("fast_outs", {18'b0, out_f, sel_f, running_f, lap_f}, {18'b0, e_frame[1], e_run, m_lap[1]});
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic run_until(input int inst, input int target, input int budget);
    int n = 0;
    while (m_cnt[inst] != target && n < budget) begin step(); n++; end
    if (m_cnt[inst] != target) begin
      n_vec++; n_err++;
      $display("FAIL run_until_%0d: gave up at %0d waiting for %0d", inst, m_cnt[inst], target);
    end
  endtask

  // Scan four digit periods, keep the glyph seen per selected digit, compare with constants.
  task automatic check_frame(input string tag, input int inst,
                             input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
    for (int k = 0; k < 4; k++) seen[k] = 8'hxx;
    for (int c = 0; c < 40; c++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        if (inst == 0 && sel_s[k] == 1'b0) seen[k] = out_s;
        if (inst == 1 && sel_f[k] == 1'b0) seen[k] = out_f;
      end
    end
    check({tag, "_d3"}, {24'b0, seen[3]}, {24'b0, e3});
    check({tag, "_d2"}, {24'b0, seen[2]}, {24'b0, e2});
    check({tag, "_d1"}, {24'b0, seen[1]}, {24'b0, e1});
    check({tag, "_d0"}, {24'b0, seen[0]}, {24'b0, e0});
  endtask

  initial begin
    logic [3:0] order[$];
    logic [3:0] prev;
    int n;
    rst = 1'b1; run = 1'b0; lap = 1'b0; clr = 1'b0;
    repeat (3) step();
    check("rst_sel", {28'b0, sel_s}, 32'h0000_000E);
    check("rst_out", {24'b0, out_s}, 32'h0000_00C0);
    check("rst_flags", {30'b0, running_s, lap_s}, 32'h0);
    rst = 1'b0;

    // Scan order: digit selects go 0,1,2,3 with glyph and select moving together.
    prev = sel_s;
    order.push_back(prev);
    for (int c = 0; c < 40; c++) begin
      step();
      if (sel_s != prev) begin prev = sel_s; order.push_back(prev); end
    end
    check("scan_len", (order.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    if (order.size() >= 4) begin
      check("scan_0", {28'b0, order[0]}, 32'hE);
      check("scan_1", {28'b0, order[1]}, 32'hD);
      check("scan_2", {28'b0, order[2]}, 32'hB);
      check("scan_3", {28'b0, order[3]}, 32'h7);
    end

    // 25 ticks -> 002.5 shown as "2.5" with upper digits blanked.
    pulse_rst();
    run = 1'b1;
    run_until(0, 25, 3000);
    run = 1'b0;
    check_frame("cnt25", 0, 8'hFF, 8'hFF, 8'h24, 8'h92);

    // Lap freeze at 0012 while the counter reaches 0030, then release.
    pulse_rst();
    run = 1'b1;
    run_until(0, 12, 1500);
    lap = 1'b1; step(); lap = 1'b0;
    check("lap_on", {31'b0, lap_s}, 32'd1);
    run_until(0, 30, 2500);
    run = 1'b0;
    check_frame("frozen", 0, 8'hFF, 8'hFF, 8'h79, 8'hA4);
    lap = 1'b1; step(); lap = 1'b0;
    check("lap_off", {31'b0, lap_s}, 32'd0);
    check_frame("live30", 0, 8'hFF, 8'hFF, 8'h30, 8'hC0);

    // Clear + lap in the same cycle as a counting tick: clear wins.
    run = 1'b1;
    n = 0;
    while ((m_cyc % 100) != 99 && n < 200) begin step(); n++; end
    clr = 1'b1; lap = 1'b1; step(); clr = 1'b0; lap = 1'b0; run = 1'b0;
    check("clr_lap", {31'b0, lap_s}, 32'd0);
    check_frame("cleared", 0, 8'hFF, 8'hFF, 8'h40, 8'hC0);

    // Reset while digit 2 is being scanned.
    run = 1'b1;
    repeat (250) step();
    n = 0;
    while (m_idx != 2 && n < 50) begin step(); n++; end
    rst = 1'b1; step(); rst = 1'b0; run = 1'b0;
    check("midrst_sel", {28'b0, sel_s}, 32'hE);
    check("midrst_out", {24'b0, out_s}, 32'hC0);
    check("midrst_run", {31'b0, running_s}, 32'd0);
    check_frame("midrst", 0, 8'hFF, 8'hFF, 8'h40, 8'hC0);

    // Fast instance: 5:59.9 then the tens-of-seconds carry into the minutes digit, then full wrap.
    pulse_rst();
    run = 1'b1;
    run_until(1, 3599, 16000);
    run = 1'b0;
    check_frame("t5599", 1, 8'h92, 8'h92, 8'h10, 8'h90);
    run = 1'b1;
    run_until(1, 3600, 200);
    run = 1'b0;
    check_frame("t6000", 1, 8'h82, 8'hC0, 8'h40, 8'hC0);
    run = 1'b1;
    run_until(1, 5999, 11000);
    run = 1'b0;
    check_frame("t9599", 1, 8'h90, 8'h92, 8'h10, 8'h90);
    run = 1'b1;
    run_until(1, 0, 200);
    run = 1'b0;
    check_frame("twrap", 1, 8'hFF, 8'hFF, 8'h40, 8'hC0);

    // Randomized run/lap/clear/reset traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(63) == 0) run = ~run;
      lap = ($urandom_range(149) == 0);
      clr = ($urandom_range(399) == 0);
      rst = ($urandom_range(1499) == 0);
      step();
    end
    rst = 1'b0; lap = 1'b0; clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
